// File: rtl/hiscore_ram_arbiter.sv
// ============================================================================
// Module   : hiscore_ram_arbiter
// Purpose  : Shares the single-port game work RAM between the Z80 CPU and the
//            hiscore save/restore engine. The CPU always has priority; hiscore
//            accesses take CPU-idle or paused cycles via a req/ack handshake.
// Ports    : clk_sys, RESET_n (async, active-low)
//            cpu_cs/cpu_we/cpu_addr/cpu_wdata -> cpu_rdata, cpu_wait
//            cpu_paused                       : CPU halted, cpu_cs ignored
//            hs_req/hs_we/hs_addr/hs_wdata    -> hs_rdata, hs_ack
//            ram_addr/ram_wdata/ram_we (registered) <- ram_rdata
// Options  : HS_ARB_STARVE_GUARD_EN - forces a hiscore slot after STARVE_MAX
//            cycles of waiting behind continuous CPU traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hiscore_ram_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 64
) (
  input  logic          clk_sys,
  input  logic          RESET_n,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_wait,
  input  logic          cpu_paused,
  input  logic          hs_req,
  input  logic          hs_we,
  input  logic [AW-1:0] hs_addr,
  input  logic [DW-1:0] hs_wdata,
  output logic [DW-1:0] hs_rdata,
  output logic          hs_ack,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  generate
    if (RAM_LAT < 1 || RAM_LAT > 3 || STARVE_MAX < 1) begin : g_bad_params
      $error("hiscore_ram_arbiter: RAM_LAT must be 1..3 and STARVE_MAX >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HS_ISSUE = 2'd1,
    S_HS_WAIT  = 2'd2,
    S_HS_ACK   = 2'd3
  } state_t;

  localparam logic [1:0] c_lat_last = 2'(RAM_LAT - 1);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [1:0]   r_wait_cnt;
  logic         w_cpu_req;
  logic         w_hs_grant;
  logic         w_cpu_grant;
  logic         w_force;
  logic [RAM_LAT:0] r_cpu_rd_pipe;
  logic [DW-1:0]    r_cpu_rdata_hold;

  // --------------------------------------------------------------------------
  // Starvation guard
  // --------------------------------------------------------------------------
`ifdef HS_ARB_STARVE_GUARD_EN
  localparam int c_sw = $clog2(STARVE_MAX + 1);
  logic [c_sw-1:0] r_starve_cnt;

  // The counter can never pass STARVE_MAX: reaching it forces a grant, which clears it.
  assign w_force = (r_state == S_IDLE) && hs_req && (r_starve_cnt == c_sw'(STARVE_MAX));

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      r_starve_cnt <= '0;
    end else if (w_hs_grant) begin
      r_starve_cnt <= '0;
    end else if ((r_state == S_IDLE) && hs_req) begin
      r_starve_cnt <= r_starve_cnt + c_sw'(1);
    end
  end
`else
  assign w_force = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Grant decision
  // --------------------------------------------------------------------------
  assign w_cpu_req   = cpu_cs && !cpu_paused;
  assign w_hs_grant  = (r_state == S_IDLE) && hs_req && (!w_cpu_req || w_force);
  assign w_cpu_grant = w_cpu_req && !w_hs_grant;

  // --------------------------------------------------------------------------
  // Hiscore FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    hs_ack      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hs_grant) w_state_nxt = S_HS_ISSUE;
      end
      // ram_we holds hs_we during the issue cycle, so it tells read from write.
      S_HS_ISSUE: w_state_nxt = ram_we ? S_HS_ACK : S_HS_WAIT;
      S_HS_WAIT: begin
        if (r_wait_cnt == c_lat_last) w_state_nxt = S_HS_ACK;
      end
      S_HS_ACK: begin
        hs_ack      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      r_wait_cnt <= 2'd0;
      hs_rdata   <= '0;
    end else begin
      if (r_state == S_HS_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 2'd1;
      end else begin
        r_wait_cnt <= 2'd0;
      end
      // Last HS_WAIT cycle is exactly RAM_LAT cycles after the issue cycle.
      if ((r_state == S_HS_WAIT) && (r_wait_cnt == c_lat_last)) begin
        hs_rdata <= ram_rdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // RAM port registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      cpu_wait  <= 1'b0;
    end else begin
      // A CPU request only loses to the hiscore engine on a forced slot.
      cpu_wait <= w_cpu_req && w_hs_grant;
      if (w_hs_grant) begin
        ram_addr  <= hs_addr;
        ram_wdata <= hs_wdata;
        ram_we    <= hs_we;
      end else if (w_cpu_grant) begin
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
        ram_we    <= cpu_we;
      end else begin
        ram_we    <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // CPU read data: bit 0 marks the port cycle of a CPU read, bit RAM_LAT the
  // cycle its data is on ram_rdata. Data passes straight through in that
  // cycle and is held afterwards.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      r_cpu_rd_pipe    <= '0;
      r_cpu_rdata_hold <= '0;
    end else begin
      r_cpu_rd_pipe <= {r_cpu_rd_pipe[RAM_LAT-1:0], w_cpu_grant && !cpu_we};
      if (r_cpu_rd_pipe[RAM_LAT]) begin
        r_cpu_rdata_hold <= ram_rdata;
      end
    end
  end

  always_comb begin
    cpu_rdata = r_cpu_rdata_hold;
    if (r_cpu_rd_pipe[RAM_LAT]) cpu_rdata = ram_rdata;
  end

endmodule

`default_nettype wire

// File: tb/tb_hiscore_ram_arbiter.sv
// ============================================================================
// Module   : tb_hiscore_ram_arbiter
// Purpose  : Directed self-checking bench for hiscore_ram_arbiter. Three DUTs
//            with RAM_LAT = 1, 2, 3 share the CPU stimulus; each has its own
//            RAM model and hs_req line. Instance 0 (RAM_LAT=1) carries the
//            detailed tests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hiscore_ram_arbiter;

  localparam int NL = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_cs, cpu_we, cpu_paused, hs_we;
  logic [15:0] cpu_addr, hs_addr;
  logic [7:0]  cpu_wdata, hs_wdata;
  logic [NL-1:0] hs_req;

  logic [7:0]  cpu_rdata_a [NL];
  logic        cpu_wait_a  [NL];
  logic [7:0]  hs_rdata_a  [NL];
  logic        hs_ack_a    [NL];
  logic [15:0] ram_addr_a  [NL];
  logic [7:0]  ram_wdata_a [NL];
  logic        ram_we_a    [NL];
  logic [7:0]  ram_rdata_a [NL];

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NL; g++) begin : g_lat
      localparam int L = g + 1;
      logic [7:0] mem [0:65535];
      logic [7:0] rpipe [L];

      hiscore_ram_arbiter #(.AW(16), .DW(8), .RAM_LAT(L), .STARVE_MAX(64)) u_dut (
        .clk_sys    (clk),
        .RESET_n    (rst_n),
        .cpu_cs     (cpu_cs),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata_a[g]),
        .cpu_wait   (cpu_wait_a[g]),
        .cpu_paused (cpu_paused),
        .hs_req     (hs_req[g]),
        .hs_we      (hs_we),
        .hs_addr    (hs_addr),
        .hs_wdata   (hs_wdata),
        .hs_rdata   (hs_rdata_a[g]),
        .hs_ack     (hs_ack_a[g]),
        .ram_addr   (ram_addr_a[g]),
        .ram_wdata  (ram_wdata_a[g]),
        .ram_we     (ram_we_a[g]),
        .ram_rdata  (ram_rdata_a[g])
      );

      // Synchronous RAM: data for the address on the port in cycle k appears
      // in cycle k+L.
      always @(posedge clk) begin
        if (ram_we_a[g]) mem[ram_addr_a[g]] <= ram_wdata_a[g];
        rpipe[0] <= mem[ram_addr_a[g]];
        for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
      end
      assign ram_rdata_a[g] = rpipe[L-1];
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int g = 0; g < NL; g++) begin
      check({tag, "_cpu_rdata"}, cpu_rdata_a[g], 0);
      check({tag, "_cpu_wait"},  cpu_wait_a[g],  0);
      check({tag, "_hs_rdata"},  hs_rdata_a[g],  0);
      check({tag, "_hs_ack"},    hs_ack_a[g],    0);
      check({tag, "_ram_addr"},  ram_addr_a[g],  0);
      check({tag, "_ram_wdata"}, ram_wdata_a[g], 0);
      check({tag, "_ram_we"},    ram_we_a[g],    0);
    end
  endtask

  int         ack_cyc [NL];
  logic [7:0] ack_dat [NL];
  int         slot_cyc, wait_n, ack0;

  initial begin
    rst_n = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_paused = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; hs_req = '0; hs_we = 1'b0;
    hs_addr = '0; hs_wdata = '0;

    // ---------------- reset state ----------------
    repeat (2) tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // ---------------- CPU write 0x5A -> 0x8123 (all instances) ----------------
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8123; cpu_wdata = 8'h5A;
    tick();
    check("cpuw_ram_we",    ram_we_a[0],    1);
    check("cpuw_ram_addr",  ram_addr_a[0],  16'h8123);
    check("cpuw_ram_wdata", ram_wdata_a[0], 8'h5A);
    check("cpuw_cpu_wait",  cpu_wait_a[0],  0);
    cpu_cs = 1'b0; cpu_we = 1'b0;
    tick();
    check("cpuw_we_drop", ram_we_a[0], 0);

    // ---------------- CPU read alignment sweep ----------------
    // Grant sampled in cycle 0; data due in cycle 1+L, held afterwards.
    cpu_cs = 1'b1; cpu_addr = 16'h8123;
    tick();
    cpu_cs = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      for (int g = 0; g < NL; g++) begin
        check($sformatf("cpurd_L%0d_c%0d", g + 1, c), cpu_rdata_a[g],
              (c >= 2 + g) ? 32'h5A : 32'h0);
      end
      if (c < 5) tick();
    end

    // ---------------- paused hiscore read, latency sweep ----------------
    cpu_paused = 1'b1; hs_we = 1'b0; hs_addr = 16'h8123; hs_req = '1;
    for (int g = 0; g < NL; g++) begin ack_cyc[g] = 0; ack_dat[g] = 8'h00; end
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) begin
        check("pr_ram_addr", ram_addr_a[0], 16'h8123);
        check("pr_ram_we",   ram_we_a[0],   0);
      end
      for (int g = 0; g < NL; g++) begin
        if (hs_ack_a[g] && hs_req[g]) begin
          ack_cyc[g] = k; ack_dat[g] = hs_rdata_a[g]; hs_req[g] = 1'b0;
        end
      end
    end
    for (int g = 0; g < NL; g++) begin
      check($sformatf("pr_ack_cycle_L%0d", g + 1), ack_cyc[g], g + 3);
      check($sformatf("pr_hs_rdata_L%0d", g + 1), ack_dat[g], 8'h5A);
    end
    hs_req = '0;

    // ---------------- cpu_cs ignored while paused ----------------
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h77;
    tick();
    check("paused_cs_ram_we",   ram_we_a[0],   0);
    check("paused_cs_ram_addr", ram_addr_a[0], 16'h8123);
    cpu_cs = 1'b0; cpu_we = 1'b0;

    // ---------------- paused hiscore write ----------------
    hs_req = 3'b001; hs_we = 1'b1; hs_addr = 16'h8010; hs_wdata = 8'hC3;
    tick();
    check("pw_ram_we",    ram_we_a[0],    1);
    check("pw_ram_addr",  ram_addr_a[0],  16'h8010);
    check("pw_ram_wdata", ram_wdata_a[0], 8'hC3);
    check("pw_ack_early", hs_ack_a[0],    0);
    tick();
    check("pw_ack",       hs_ack_a[0],    1);
    check("pw_we_single", ram_we_a[0],    0);
    hs_req = '0; hs_we = 1'b0;
    tick();
    check("pw_ack_pulse", hs_ack_a[0],    0);
    cpu_paused = 1'b0;
    cpu_cs = 1'b1; cpu_addr = 16'h8010;
    tick();
    cpu_cs = 1'b0;
    tick();
    check("pw_readback", cpu_rdata_a[0], 8'hC3);

    // ---------------- collision: CPU wins, hiscore on first idle ----------------
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8000;
    hs_req = 3'b001; hs_we = 1'b0; hs_addr = 16'h8123;
    tick();
    check("coll_c1_addr", ram_addr_a[0], 16'h8000);
    check("coll_c1_wait", cpu_wait_a[0], 0);
    cpu_addr = 16'h8001;
    tick();
    check("coll_c2_addr", ram_addr_a[0], 16'h8001);
    check("coll_c2_wait", cpu_wait_a[0], 0);
    cpu_cs = 1'b0;
    tick();
    check("coll_hs_issue", ram_addr_a[0], 16'h8123);
    tick();
    check("coll_ack_early", hs_ack_a[0], 0);
    tick();
    check("coll_ack",      hs_ack_a[0],  1);
    check("coll_hs_rdata", hs_rdata_a[0], 8'h5A);
    hs_req = '0;
    tick();

    // ---------------- continuous CPU traffic with hs_req pending ----------------
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    hs_req = 3'b001; hs_we = 1'b0; hs_addr = 16'h8123;
    slot_cyc = 0; wait_n = 0; ack0 = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (cpu_wait_a[0]) wait_n++;
      if (ram_addr_a[0] == 16'h8123 && slot_cyc == 0) slot_cyc = k;
      if (hs_ack_a[0] && hs_req[0]) begin ack0 = k; hs_req[0] = 1'b0; end
    end
`ifdef HS_ARB_STARVE_GUARD_EN
    check("b2b_slot_cycle", slot_cyc, 65);
    check("b2b_wait_count", wait_n,   1);
    check("b2b_ack_cycle",  ack0,     67);
`else
    check("b2b_slot_cycle", slot_cyc, 0);
    check("b2b_wait_count", wait_n,   0);
    check("b2b_no_ack",     ack0,     0);
`endif
    cpu_cs = 1'b0;
    for (int k = 201; k <= 210; k++) begin
      tick();
      if (hs_ack_a[0] && hs_req[0]) begin ack0 = k; hs_req[0] = 1'b0; end
    end
`ifndef HS_ARB_STARVE_GUARD_EN
    check("b2b_ack_after_idle", ack0, 203);
`endif
    hs_req = '0;
    tick();

    // ---------------- reset in the middle of HS_WAIT ----------------
    cpu_paused = 1'b1; hs_we = 1'b0; hs_addr = 16'h8123; hs_req = '1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rstmid");
    hs_req = '0;
    tick();
    rst_n = 1'b1;
    tick();
    hs_req = 3'b001;
    ack0 = 0; ack_dat[0] = 8'h00;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (hs_ack_a[0] && hs_req[0]) begin
        ack0 = k; ack_dat[0] = hs_rdata_a[0]; hs_req[0] = 1'b0;
      end
    end
    check("rstmid_restart_ack",   ack0,       3);
    check("rstmid_restart_rdata", ack_dat[0], 8'h5A);
    hs_req = '0; cpu_paused = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
